// File: rtl/rom_read_arbiter_pkg.sv
// rom_arb_pkg: shared types and constants for the ROM read arbiter.
//   arb_state_t       : arbitration FSM states (ARB, LOCK)
//   req_id_w()        : width of a requester ID for a given requester count
//   ROM_DEPTH_DEFAULT : number of valid words in the sprite/screen ROM
package rom_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int unsigned ROM_DEPTH_DEFAULT = 15001;

  function automatic int unsigned req_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_read_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority pick.
//   req   : request vector
//   mask  : eligibility mask (only req & mask may win)
//   ptr   : last winner; search starts at ptr+1 modulo N
//   gnt   : one-hot grant
//   idx   : index of the granted requester
//   found : any grant issued
module rr_picker #(
  parameter int unsigned N   = 3,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           found
);

  int unsigned   c;
  logic [IDW-1:0] ci;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      c  = (32'(ptr) + k) % N;
      ci = IDW'(c);
      if (!found && req[ci] && mask[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one synchronous-read ROM between NUM_REQ readers.
// Round-robin arbitration with optional per-requester lock (bounded by
// MAX_BURST); one address issued per cycle; each returned word is tagged with
// its requester ID two cycles after the accept edge.
// Ports:
//   Clk, Reset (async, active-high)
//   req_i/lock_i/addr_i : per-requester request, lock and packed address
//   gnt_o               : one-hot combinational accept
//   rom_addr_o          : registered ROM address; rom_data_i : ROM data
//   rdata_valid_o/rdata_id_o/rdata_o/rdata_err_o : tagged return beat
// Optional: define ROM_ARB_RANGE_CHECK_EN to replace out-of-range addresses
// with 0 and flag the returned beat with rdata_err_o.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEFAULT,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0]       addr_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [ADDR_W-1:0]               rom_addr_o,
  input  logic [DATA_W-1:0]               rom_data_i,
  output logic                            rdata_valid_o,
  output logic [req_id_w(NUM_REQ)-1:0]    rdata_id_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic                            rdata_err_o
);

  localparam int unsigned IDW = req_id_w(NUM_REQ);
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  arb_state_t     state;
  logic [IDW-1:0] rr_ptr;
  logic [BCW-1:0] burst_cnt;

  logic [NUM_REQ-1:0] pick_mask;
  logic [IDW-1:0]     win_idx;
  logic               found;
  logic [ADDR_W-1:0]  win_addr;
  logic               oor;

  // Two-stage tag pipeline: stage 1 tracks the address register, stage 2
  // lines up with the ROM's registered data.
  logic           v1, v2;
  logic [IDW-1:0] id1, id2;
  logic           err1, err2;

  // While locked, rr_ptr always equals the owner (every grant updates it),
  // so the owner mask is derived from the pointer itself.
  always_comb begin
    pick_mask = '1;
    if (state == LOCK) begin
      pick_mask         = '0;
      pick_mask[rr_ptr] = 1'b1;
    end
  end

  rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (req_i),
    .mask  (pick_mask),
    .ptr   (rr_ptr),
    .gnt   (gnt_o),
    .idx   (win_idx),
    .found (found)
  );

  assign win_addr = addr_i[win_idx*ADDR_W +: ADDR_W];

`ifdef ROM_ARB_RANGE_CHECK_EN
  assign oor = (32'(win_addr) >= ROM_DEPTH);
`else
  assign oor = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ARB;
      rr_ptr     <= IDW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      rom_addr_o <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      id1        <= '0;
      id2        <= '0;
      err1       <= 1'b0;
      err2       <= 1'b0;
    end else begin
      v2   <= v1;
      id2  <= id1;
      err2 <= err1;
      v1   <= found;
      if (found) begin
        id1        <= win_idx;
        err1       <= oor;
        rom_addr_o <= oor ? '0 : win_addr;
        rr_ptr     <= win_idx;
      end
      case (state)
        ARB: begin
          if (found && lock_i[win_idx] && (MAX_BURST > 1)) begin
            state     <= LOCK;
            burst_cnt <= BCW'(1);
          end
        end
        LOCK: begin
          if (found) begin
            // Break the lock on the grant that would reach MAX_BURST.
            if (lock_i[win_idx] && (32'(burst_cnt) + 1 < MAX_BURST)) begin
              burst_cnt <= burst_cnt + BCW'(1);
            end else begin
              state     <= ARB;
              burst_cnt <= '0;
            end
          end else if (!req_i[rr_ptr] && !lock_i[rr_ptr]) begin
            state     <= ARB;
            burst_cnt <= '0;
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  assign rdata_valid_o = v2;
  assign rdata_id_o    = id2;
  assign rdata_err_o   = v2 & err2;
  assign rdata_o       = (v2 && !err2) ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
module tb_rom_read_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 15;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [NR-1:0] req_i = '0;
  logic [NR-1:0] lock_i = '0;
  logic [NR*AW-1:0] addr_i = '0;
  logic [NR-1:0] gnt_o;
  logic [AW-1:0] rom_addr_o;
  logic [0:0]    rom_data_i;
  logic          rdata_valid_o;
  logic [1:0]    rdata_id_o;
  logic [0:0]    rdata_o;
  logic          rdata_err_o;

  rom_read_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_W    (AW),
    .DATA_W    (1),
    .ROM_DEPTH (15001),
    .MAX_BURST (4)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .req_i         (req_i),
    .lock_i        (lock_i),
    .addr_i        (addr_i),
    .gnt_o         (gnt_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .rdata_valid_o (rdata_valid_o),
    .rdata_id_o    (rdata_id_o),
    .rdata_o       (rdata_o),
    .rdata_err_o   (rdata_err_o)
  );

  always #5 Clk = ~Clk;

  // ROM contents: word(a) = a[1]^a[2]  (10 -> 1, 20 -> 1, 30 -> 0)
  function automatic logic rom_fn(input logic [AW-1:0] a);
    return a[1] ^ a[2];
  endfunction

  logic rom_q = 1'b0;
  always @(posedge Clk) rom_q <= rom_fn(rom_addr_o);
  assign rom_data_i = rom_q;

  typedef struct {
    int   id;
    logic data;
    logic err;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    logic [NR*AW-1:0] v;
    v = addr_i;
    return v[i*AW +: AW];
  endfunction

  function automatic logic is_oor(input logic [AW-1:0] a);
`ifdef ROM_ARB_RANGE_CHECK_EN
    return (32'(a) >= 15001);
`else
    return 1'b0;
`endif
  endfunction

  // One arbitration cycle: drive at negedge, check the combinational grant,
  // and record the expected return beat when a grant is due.
  task automatic cycle(input logic [NR-1:0] rq, input logic [NR-1:0] lk, input int exp_gnt);
    logic [NR-1:0] eg;
    exp_t e;
    @(negedge Clk);
    req_i  = rq;
    lock_i = lk;
    #1;
    eg = '0;
    if (exp_gnt >= 0) eg[exp_gnt] = 1'b1;
    check("gnt_o", 32'(gnt_o), 32'(eg));
    if (exp_gnt >= 0) begin
      e.id   = exp_gnt;
      e.err  = is_oor(addr_of(exp_gnt));
      e.data = e.err ? 1'b0 : rom_fn(addr_of(exp_gnt));
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every presented beat against the scoreboard.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (rdata_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(rdata_id_o), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdata_id_o", 32'(rdata_id_o), 32'(e.id));
          check("rdata_o", 32'(rdata_o), 32'(e.data));
          check("rdata_err_o", 32'(rdata_err_o), 32'(e.err));
        end
      end else begin
        check("rdata_o_idle", 32'(rdata_o), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] held;
    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_valid", 32'(rdata_valid_o), 32'd0);
    check("rst_id", 32'(rdata_id_o), 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    check("rst_err", 32'(rdata_err_o), 32'd0);
    check("rst_addr", 32'(rom_addr_o), 32'd0);
    Reset = 1'b0;

    // Idle
    for (int i = 0; i < 5; i++) cycle(3'b000, 3'b000, -1);
    check("idle_addr", 32'(rom_addr_o), 32'd0);
    check("idle_valid", 32'(rdata_valid_o), 32'd0);

    // Round-robin, no lock
    addr_i = {15'd30, 15'd20, 15'd10};
    cycle(3'b111, 3'b000, 0);
    cycle(3'b111, 3'b000, 1);
    cycle(3'b111, 3'b000, 2);
    cycle(3'b111, 3'b000, 0);
    cycle(3'b111, 3'b000, 1);
    cycle(3'b111, 3'b000, 2);
    for (int i = 0; i < 3; i++) cycle(3'b000, 3'b000, -1);
    check("rr_addr_hold", 32'(rom_addr_o), 32'd30);

    // Lock burst bounded at 4 grants, then 2, then 0
    cycle(3'b001, 3'b000, 0);
    cycle(3'b111, 3'b010, 1);
    cycle(3'b111, 3'b010, 1);
    cycle(3'b111, 3'b010, 1);
    cycle(3'b111, 3'b010, 1);
    cycle(3'b111, 3'b010, 2);
    cycle(3'b111, 3'b010, 0);
    cycle(3'b000, 3'b000, -1);

    // Lock held while others wait, released when owner drops req and lock
    cycle(3'b010, 3'b010, 1);
    cycle(3'b101, 3'b000, -1);
    cycle(3'b101, 3'b000, 2);
    for (int i = 0; i < 3; i++) cycle(3'b000, 3'b000, -1);

    // Reset in the cycle after an accept drops the in-flight read
    cycle(3'b001, 3'b000, 0);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    req_i = '0;
    exp_q.delete();
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 3'b000, -1);
      check("post_rst_valid", 32'(rdata_valid_o), 32'd0);
    end
    cycle(3'b111, 3'b000, 0);
    for (int i = 0; i < 3; i++) cycle(3'b000, 3'b000, -1);

    // Out-of-range address
    addr_i = {15'd30, 15'd20, 15'd15001};
    cycle(3'b001, 3'b000, 0);
    @(posedge Clk);
    #1;
`ifdef ROM_ARB_RANGE_CHECK_EN
    check("oor_addr", 32'(rom_addr_o), 32'd0);
`else
    check("oor_addr", 32'(rom_addr_o), 32'd15001);
`endif
    held = rom_addr_o;
    for (int i = 0; i < 4; i++) cycle(3'b000, 3'b000, -1);
    check("addr_hold", 32'(rom_addr_o), 32'(held));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
